// File: rtl/capture_pkg.sv
// Shared types and encodings for the capture_x input-capture peripheral.
package capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] MODE_PERIOD = 2'b00;
    localparam logic [1:0] MODE_HIGH   = 2'b01;
    localparam logic [1:0] MODE_LOW    = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    localparam logic [1:0] CH_CTRL   = 2'd0;
    localparam logic [1:0] CH_RESULT = 2'd1;
    localparam logic [1:0] CH_STATUS = 2'd2;
    localparam logic [1:0] CH_LIMIT  = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE    = 1;
    localparam int CTRL_IRQ_EN  = 3;
    localparam int CTRL_ONESHOT = 4;
    localparam int CTRL_W       = 5;

    localparam int STAT_OVF = 1;
    localparam int STAT_W   = 3;

    // Reserved mode 11 measures period.
    function automatic logic is_period(input logic [1:0] mode);
        return (mode == MODE_PERIOD) || (mode == MODE_RSVD);
    endfunction

    function automatic logic starts_on_fall(input logic [1:0] mode);
        return mode == MODE_LOW;
    endfunction

    function automatic logic ends_on_fall(input logic [1:0] mode);
        return mode == MODE_HIGH;
    endfunction

endpackage

// File: rtl/capture_x_if.sv
// Channel-addressed register bus of capture_x plus its level interrupt.
interface capture_x_if #(
    parameter int CNT_W = 32
);
    logic             cap_we;
    logic             cap_re;
    logic [1:0]       cap_ch;
    logic [CNT_W-1:0] cap_val;
    logic [CNT_W-1:0] cap_out;
    logic             cap_irq;

    modport master (
        output cap_we, cap_re, cap_ch, cap_val,
        input  cap_out, cap_irq
    );

    modport slave (
        input  cap_we, cap_re, cap_ch, cap_val,
        output cap_out, cap_irq
    );
endinterface

// File: rtl/capture_x_sync_edge.sv
// Two-flop synchronizer followed by a registered edge detector.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    // level is the settled value that the pending edge pulse describes
    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule

// File: rtl/capture_x.sv
// Input-capture peripheral: measures period / high width / low width of cap_in in tick units.
//   state | meaning
//   IDLE  | disabled, cnt held at 0
//   ARM   | waiting for the mode's start edge
//   MEAS  | counting ticks until the end edge, timeout or wrap
//   DONE  | one-shot capture taken, holding until CTRL is written
module capture_x
    import capture_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      cap_in,
    input  logic      tick,
    capture_x_if.slave bus
);
    state_e             state_q, state_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               ovf_q, ovf_d;

    logic               in_level, in_rise, in_fall;
    logic               rise_ok, fall_ok, start_edge, end_edge;
    logic [1:0]         mode;
    logic               wrap, timeout, busy;
    logic [CNT_W-1:0]   cnt_inc, cnt_sat;
    logic               wr_ctrl, wr_status, wr_limit, rd_result;

    sync_edge u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (cap_in),
        .level (in_level),
        .rise  (in_rise),
        .fall  (in_fall)
    );

    assign mode       = ctrl_q[CTRL_MODE +: 2];
    assign rise_ok    = in_rise & in_level;
    assign fall_ok    = in_fall & ~in_level;
    assign start_edge = starts_on_fall(mode) ? fall_ok : rise_ok;
    assign end_edge   = ends_on_fall(mode) ? fall_ok : rise_ok;

    assign wrap    = (&cnt_q) & tick;
    assign cnt_inc = cnt_q + CNT_W'(tick);
    assign cnt_sat = wrap ? cnt_q : cnt_inc;
    assign timeout = wrap | ((limit_q != '0) && (cnt_inc >= limit_q));

    assign wr_ctrl   = bus.cap_we && (bus.cap_ch == CH_CTRL);
    assign wr_status = bus.cap_we && (bus.cap_ch == CH_STATUS);
    assign wr_limit  = bus.cap_we && (bus.cap_ch == CH_LIMIT);
    assign rd_result = bus.cap_re && (bus.cap_ch == CH_RESULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            limit_q  <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            limit_q  <= limit_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    // Flag clears are applied first so a same-cycle set overrides them.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        limit_d  = limit_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;

        if (rd_result)
            valid_d = 1'b0;
        if (wr_status && bus.cap_val[STAT_OVF])
            ovf_d = 1'b0;
        if (wr_limit)
            limit_d = bus.cap_val;

        if (wr_ctrl) begin
            ctrl_d  = bus.cap_val[CTRL_W-1:0];
            cnt_d   = '0;
            state_d = bus.cap_val[CTRL_EN] ? ST_ARM : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: cnt_d = '0;
                ST_ARM: begin
                    if (start_edge) begin
                        cnt_d   = '0;
                        state_d = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (end_edge) begin
                        result_d = cnt_sat;
                        valid_d  = 1'b1;
                        if (ctrl_q[CTRL_ONESHOT])
                            state_d = ST_DONE;
                        else if (is_period(mode))
                            cnt_d = '0;
                        else
                            state_d = ST_ARM;
                    end else if (timeout) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_ARM;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_ARM) || (state_q == ST_MEAS);

    always_comb begin
        bus.cap_out = '0;
        case (bus.cap_ch)
            CH_CTRL:   bus.cap_out = CNT_W'(ctrl_q);
            CH_RESULT: bus.cap_out = result_q;
            CH_STATUS: bus.cap_out = CNT_W'({busy, ovf_q, valid_q});
            CH_LIMIT:  bus.cap_out = limit_q;
            default:   bus.cap_out = '0;
        endcase
    end

    assign bus.cap_irq = ctrl_q[CTRL_IRQ_EN] & (valid_q | ovf_q);

endmodule
